// File: rtl/key_pkg.sv
// Shared constants and helpers for the smart-car key front end.
// Key roles, default and simulation timing, and the mode-update action type.
package key_pkg;

  localparam int KEY_INC  = 0;
  localparam int KEY_DEC  = 1;
  localparam int KEY_RST  = 2;
  localparam int KEY_LOCK = 3;

  // 20 ms debounce and 1 s long press at 50 MHz; short values for simulation
  localparam int DEF_DEBOUNCE = 1000000;
  localparam int DEF_LONG     = 50000000;
  localparam int SIM_DEBOUNCE = 4;
  localparam int SIM_LONG     = 20;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_INC,
    ACT_DEC,
    ACT_CLEAR
  } mode_act_e;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One push-button channel: 2-flop synchroniser, counter debouncer,
// and press / release / long-press single-cycle event pulses.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE,
  parameter int LONG_CYC     = DEF_LONG
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? clog2(DEBOUNCE_CYC) : 1;
  localparam int HW = clog2(LONG_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);

  logic [1:0]    sync_q;
  logic          sync;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hcnt;

  // Presets to 1 so a reset looks like a released button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], key_n};
  end

  assign sync = ~sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt           <= '0;
        level         <= sync;
        press_pulse   <= sync;
        release_pulse <= ~sync;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Saturating hold counter gives exactly one long pulse per press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt       <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (!level) begin
        hcnt <= '0;
      end else if (hcnt != HOLD_MAX) begin
        hcnt       <= hcnt + HW'(1);
        long_pulse <= (hcnt == HOLD_LAST);
      end
    end
  end

endmodule

// File: rtl/key_mode_ctrl.sv
// N-channel key front end with the car's operating-mode register.
// Keys 0..3 drive increment, decrement, long-press clear and lock toggle.
module key_mode_ctrl
  import key_pkg::*;
#(
  parameter  int N_KEYS       = 4,
  parameter  int DEBOUNCE_CYC = DEF_DEBOUNCE,
  parameter  int LONG_CYC     = DEF_LONG,
  parameter  int N_MODES      = 4,
  localparam int MODE_W       = clog2(N_MODES)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [MODE_W-1:0] sel_type,
  output logic              mode_lock,
  output logic              mode_change
);

  localparam logic [MODE_W-1:0] SEL_LAST = MODE_W'(N_MODES - 1);

  logic [MODE_W-1:0] sel_q, sel_d;
  logic              lock_q, lock_d;
  logic              chg_q, chg_d;
  mode_act_e         act;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC)
    ) u_ch (
      .clk          (sys_clk),
      .rst          (sys_rst),
      .key_n        (key_n[i]),
      .level        (key_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i])
    );
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sel_q  <= '0;
      lock_q <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      lock_q <= lock_d;
      chg_q  <= chg_d;
    end
  end

  // Clear beats inc/dec; the lock toggle always uses the pre-update lock value
  always_comb begin
    act = ACT_HOLD;
    if (long_pulse[KEY_RST])
      act = ACT_CLEAR;
    else if (!lock_q && press_pulse[KEY_INC] && !press_pulse[KEY_DEC])
      act = ACT_INC;
    else if (!lock_q && press_pulse[KEY_DEC] && !press_pulse[KEY_INC])
      act = ACT_DEC;

    lock_d = lock_q ^ press_pulse[KEY_LOCK];

    sel_d = sel_q;
    case (act)
      ACT_CLEAR: sel_d = '0;
      ACT_INC:   sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + MODE_W'(1);
      ACT_DEC:   sel_d = (sel_q == '0) ? SEL_LAST : sel_q - MODE_W'(1);
      default:   sel_d = sel_q;
    endcase

    chg_d = (sel_d != sel_q);
  end

  always_comb begin
    sel_type    = sel_q;
    mode_lock   = lock_q;
    mode_change = chg_q;
  end

endmodule
